// File: rtl/pipeline_multiplier_vr.sv
// pipeline_multiplier_vr: STAGES-deep global-stall pipelined multiplier with a
// valid/ready handshake, a global enable and a count of valid stages.
// The exact 2*WIDTH-bit product is formed on the way into stage 1. Later stages
// only carry it, so the signedness of each sample travels with its product.
module pipeline_multiplier_vr #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           EN,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               A,
  input  logic [WIDTH-1:0]               B,
  input  logic                           signed_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2*WIDTH-1:0]             Y,
  output logic [$clog2(STAGES+1)-1:0]    inflight
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(STAGES + 1);

  logic              stall;
  logic              advance;
  logic [PW-1:0]     ext_a;
  logic [PW-1:0]     ext_b;
  logic [PW-1:0]     prod_in;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] src_vld;
  logic [PW-1:0]     prod_q   [STAGES];
  logic [PW-1:0]     src_prod [STAGES];
  logic [CW-1:0]     cnt;

  // Extend operands to the product width, then multiply modulo 2^(2*WIDTH).
  // The low half of a sign-extended product is the exact two's-complement result.
  always_comb begin
    ext_a   = signed_mode ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
    ext_b   = signed_mode ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
    prod_in = ext_a * ext_b;
  end

  // Global stall: the whole pipe holds while an unconsumed product sits at the output.
  always_comb begin
    stall    = out_valid & ~out_ready;
    advance  = EN & ~reset & ~stall;
    in_ready = advance;
  end

  // Source of each stage: stage 1 takes the input, stage k takes stage k-1.
  always_comb begin
    src_vld[0]  = in_valid;
    src_prod[0] = prod_in;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_vld[k]  = vld_q[k-1];
      src_prod[k] = prod_q[k-1];
    end
  end

  // Stage registers. The last stage only captures real products, so Y keeps its
  // last value while bubbles pass through.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        prod_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q <= src_vld;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if ((k != STAGES - 1) || src_vld[k]) begin
          prod_q[k] <= src_prod[k];
        end
      end
    end
  end

  // Occupancy is the population count of the stage valid bits.
  always_comb begin
    cnt = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      cnt = cnt + CW'(vld_q[k]);
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign Y         = prod_q[STAGES-1];
  assign inflight  = cnt;

endmodule
